// File: rtl/rca_seq_adder.sv
// Wide adder that reuses one 4-bit ripple-carry adder, one slice per cycle, LSB first.
// Latency: out_valid rises SLICES edges after acceptance; in_ready is low from acceptance until the result is taken.
// Backpressure: DONE holds out_sum/out_cout stable until out_ready; nothing is queued meanwhile.
`timescale 1ns/1ps

module ripple_carry_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   always_comb begin
      c   = '0;
      sum = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[4];
endmodule

module rca_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);
   localparam int SLICES = WIDTH / 4;
   localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IDXW-1:0]  idx;
   logic             carry_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;

   logic [3:0] slice_a;
   logic [3:0] slice_b;
   logic [3:0] slice_sum;
   logic       slice_cout;

   assign slice_a = a_reg[4*idx +: 4];
   assign slice_b = b_reg[4*idx +: 4];

   ripple_carry_adder u_rca (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // rst_n gates in_ready so no operand can be offered as accepted during reset.
   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry_reg <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= in_a;
                  b_reg     <= in_b;
                  carry_reg <= in_cin;
                  out_sum   <= '0;
                  out_cout  <= 1'b0;
                  idx       <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               out_sum[4*idx +: 4] <= slice_sum;
               carry_reg           <= slice_cout;
               if (idx == LAST) begin
                  out_cout <= slice_cout;
                  idx      <= '0;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder (WIDTH=16): inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps

module tb_rca_seq_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rca_seq_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; offers operands and returns on the falling edge after acceptance.
   task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic drop_valid);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      check("accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (drop_valid) in_valid = 1'b0;
      check("run_busy", 32'(busy), 32'd1);
   endtask

   // Counts edges from acceptance until out_valid; bounded so a stuck DUT still reaches the summary.
   task automatic wait_result(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", 32'(out_valid), 32'd0);
      check("release_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_sum, input logic exp_cout);
      int n;
      accept(a, b, cin, 1'b1);
      wait_result(n);
      check({tag, "_latency"}, 32'(n), 32'd4);
      check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
      release_result();
   endtask

   initial begin
      int n;
      int cyc;
      int last_acc;
      int n_acc;
      int n_res;
      int seen_valid;
      logic [16:0] exp_q[$];
      logic [16:0] e;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_cout", 32'(out_cout), 32'd0);
      rst_n = 1'b1;
      #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      do_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
      do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      do_op("alt", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
      do_op("mix", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

      // Backpressure: result must hold while out_ready is low.
      accept(16'h00FF, 16'h0F0F, 1'b0, 1'b1);
      wait_result(n);
      check("bp_latency", 32'(n), 32'd4);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_sum", 32'(out_sum), 32'h100E);
         check("bp_cout", 32'(out_cout), 32'd0);
      end
      release_result();

      // Operands offered while busy are ignored; no second result is queued.
      accept(16'h0001, 16'h0001, 1'b0, 1'b0);
      in_a = 16'hFFFF; in_b = 16'hFFFF;
      wait_result(n);
      check("ign_latency", 32'(n), 32'd4);
      check("ign_sum", 32'(out_sum), 32'h0002);
      check("ign_cout", 32'(out_cout), 32'd0);
      check("ign_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("ign_idle_valid", 32'(out_valid), 32'd0);
      check("ign_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(n);
      check("ign_next_latency", 32'(n), 32'd4);
      check("ign_next_sum", 32'(out_sum), 32'hFFFE);
      check("ign_next_cout", 32'(out_cout), 32'd1);
      release_result();

      // Reset on the second RUN edge abandons the operation.
      accept(16'h1111, 16'h2222, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_sum", 32'(out_sum), 32'd0);
      check("mid_rst_cout", 32'(out_cout), 32'd0);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen_valid++;
      end
      check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
      do_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

      // Streaming with both handshakes held high.
      in_valid = 1'b1; out_ready = 1'b1;
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      cyc = 0; last_acc = 0; n_acc = 0; n_res = 0;
      while (n_res < 20 && cyc < 300) begin
         if (out_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
            check("b2b_result", 32'({out_cout, out_sum}), 32'(e));
            n_res++;
         end
         if (in_ready && in_valid) begin
            if (n_acc > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            exp_q.push_back(17'(in_a) + 17'(in_b) + 17'(in_cin));
            n_acc++;
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (n_acc >= 20) in_valid = 1'b0;
         in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      end
      check("b2b_results", 32'(n_res), 32'd20);
      in_valid = 1'b0; out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rca_seq_adder.md
Name: rca_seq_adder

Overview:
Multi-cycle sequencer that adds WIDTH-bit operands by time-sharing one instance of the 4-bit ripple_carry_adder (ports a, b, cin, sum, cout). It processes one 4-bit slice per cycle, starting at the LSB, and carries between slices in a register. A valid/ready handshake is used on both the operand side and the result side. It sits between an operand producer and a result consumer wherever a wide add is needed but only the 4-bit adder is available.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- SLICES (localparam), WIDTH/4, number of adder passes per operation.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands are present.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to slice 0.
- out_valid  output  1  result is available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  sum register.
- out_cout  output  1  carry-out of the final slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=0, out_sum=0, out_cout=0. in_ready = (state==IDLE) && rst_n, so in_ready is 0 while rst_n is low.
- Three-state FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On an edge with in_valid && in_ready: a_reg<=in_a, b_reg<=in_b, carry_reg<=in_cin, out_sum<=0, out_cout<=0, idx<=0, state<=RUN.
- RUN:
  - in_ready=0, busy=1.
  - Adder inputs: a=a_reg[4*idx+:4], b=b_reg[4*idx+:4], cin=carry_reg.
  - Each edge: out_sum[4*idx+:4]<=sum, carry_reg<=cout, idx<=idx+1.
  - On the edge where idx==SLICES-1: out_cout<=cout, idx<=0, state<=DONE.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - out_sum and out_cout hold stable until out_valid && out_ready is seen at an edge; then state<=IDLE.
  - No same-cycle acceptance of new operands in DONE.
- Latency: with the acceptance edge at T, out_valid is high after edge T+SLICES (T+4 for WIDTH=16).
- Throughput: with out_ready tied high, the minimum accept-to-accept spacing is SLICES+2 edges (6 for WIDTH=16).
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1). No overflow flag.
- Operands are captured at acceptance. Later changes on in_a, in_b or in_cin, and any in_valid pulses during RUN/DONE, are ignored; nothing is queued.
- out_ready is ignored outside DONE.
- Reset mid-operation (RUN or DONE): the operation is abandoned, no out_valid is produced, and all reset values apply on that edge.
- Only combinational path: in_ready depends on rst_n and state. out_valid and busy decode from state only. No input-to-output combinational paths besides rst_n->in_ready.

Test Plan:
- Reset, then accept a=0x0000, b=0x0000, cin=0 -> out_valid rises exactly 4 edges after acceptance with out_sum=0x0000, out_cout=0. Before that, in_ready=0 while rst_n=0 and in_ready=1 after release.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x0000, out_cout=1. Also a=0xAAAA, b=0x5555, cin=1 -> out_sum=0x0000, out_cout=1. Also a=0x1234, b=0x4321, cin=0 -> 0x5555, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with a=0x00FF, b=0x0F0F -> out_valid stays 1 and out_sum stays 0x100E, cout=0 throughout. Raising out_ready gives IDLE on the next edge.
- Busy ignore: accept a=0x0001, b=0x0001. During RUN drive in_valid=1 with a=0xFFFF, b=0xFFFF -> result is 0x0002, cout=0, and only one result is produced. The next accept occurs only after return to IDLE.
- Reset mid-RUN: accept an operation, assert rst_n=0 at the 2nd RUN edge -> state IDLE, out_sum=0, out_cout=0, out_valid never asserted. A subsequent 0x8000+0x8000 gives out_sum=0x0000, cout=1.
- Back-to-back: in_valid and out_ready tied high with a random stream of 20 operand pairs -> accepts every 6 edges, and every result matches the reference sum.
